// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with an internal return-address stack.
// Holds the current PC and selects the next PC from a small opcode:
// increment, conditional relative branch, absolute jump/load and call/return.
// All arithmetic wraps modulo 2^WIDTH. Overflow and underflow are sticky
// until reset.
module pc_sequencer #(
    parameter int WIDTH        = 16,
    parameter int STEP         = 1,
    parameter int RESET_VECTOR = 0,
    parameter int STACK_DEPTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic [2:0]                           op,
    input  logic                                 taken,
    input  logic [WIDTH-1:0]                     offset,
    input  logic [WIDTH-1:0]                     PC_In,
    output logic [WIDTH-1:0]                     PC_output,
    output logic [WIDTH-1:0]                     pc_next,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_count,
    output logic                                 stack_full,
    output logic                                 stack_empty,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_LOAD   = 3'b101;

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
    localparam logic [PTR_W-1:0] CNT_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] CNT_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(STACK_DEPTH);

    // Architectural state
    logic [WIDTH-1:0] pc_r;
    logic [PTR_W-1:0] count_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             full_r;
    logic             empty_r;
    logic [WIDTH-1:0] stack_mem_r [STACK_DEPTH];

    // Next-state decode
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] pc_branch_s;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] top_s;
    logic [IDX_W-1:0] top_idx_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [PTR_W-1:0] count_next_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             set_ovf_s;
    logic             set_unf_s;

    // The sequential address doubles as the return address pushed by CALL.
    assign pc_inc_s    = pc_r + STEP_W;
    // Displacement is relative to the current PC, not to PC+STEP.
    assign pc_branch_s = pc_r + offset;

    // Stack occupancy decode, used for the push/pop decisions this cycle.
    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);

    // Top of stack is slot count-1; the value is only used when not empty.
    assign top_idx_s  = IDX_W'(count_r - CNT_ONE);
    assign push_idx_s = IDX_W'(count_r);
    assign top_s      = stack_mem_r[top_idx_s];

    // Opcode decode: next PC, stack push/pop and error-flag set requests.
    always_comb begin
        pc_next_s = pc_inc_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        set_ovf_s = 1'b0;
        set_unf_s = 1'b0;
        case (op)
            OP_INC: begin
                pc_next_s = pc_inc_s;
            end
            OP_BRANCH: begin
                if (taken) begin
                    pc_next_s = pc_branch_s;
                end else begin
                    pc_next_s = pc_inc_s;
                end
            end
            OP_JUMP, OP_LOAD: begin
                pc_next_s = PC_In;
            end
            OP_CALL: begin
                // A call still transfers control when the stack is full;
                // only the return address is lost.
                pc_next_s = PC_In;
                if (full_s) begin
                    set_ovf_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end
            OP_RET: begin
                // A return with nothing stacked falls through sequentially.
                if (empty_s) begin
                    pc_next_s = pc_inc_s;
                    set_unf_s = 1'b1;
                end else begin
                    pc_next_s = top_s;
                    pop_s     = 1'b1;
                end
            end
            default: begin
                pc_next_s = pc_inc_s;
            end
        endcase
    end

    // Stack pointer update for the current push or pop request.
    always_comb begin
        count_next_s = count_r;
        if (push_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // PC, stack pointer, occupancy and sticky flags; reset has priority over the stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r        <= RESET_PC;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
        end else if (en) begin
            pc_r        <= pc_next_s;
            count_r     <= count_next_s;
            overflow_r  <= overflow_r | set_ovf_s;
            underflow_r <= underflow_r | set_unf_s;
            full_r      <= (count_next_s == CNT_FULL);
            empty_r     <= (count_next_s == CNT_ZERO);
        end
    end

    // Return-address storage; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (reset && en && push_s) begin
            stack_mem_r[push_idx_s] <= pc_inc_s;
        end
    end

    assign PC_output   = pc_r;
    assign pc_next     = pc_next_s;
    assign stack_count = count_r;
    assign stack_full  = full_r;
    assign stack_empty = empty_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (depth-4 stack). Each drive step runs a
// reference model and pushes the expected post-edge state onto a scoreboard;
// the scenario tasks pop and compare after the edge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  op;
    logic        taken;
    logic [15:0] offset;
    logic [15:0] PC_In;
    logic [15:0] PC_output;
    logic [15:0] pc_next;
    logic [2:0]  stack_count;
    logic        stack_full;
    logic        stack_empty;
    logic        overflow;
    logic        underflow;

    pc_sequencer #(
        .WIDTH(16), .STEP(1), .RESET_VECTOR(0), .STACK_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .taken(taken),
        .offset(offset), .PC_In(PC_In), .PC_output(PC_output),
        .pc_next(pc_next), .stack_count(stack_count),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] INC = 3'd0, BR = 3'd1, JMP = 3'd2, CALL = 3'd3,
                           RET = 3'd4, LOAD = 3'd5;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic        tk;
        logic [15:0] off;
        logic [15:0] tgt;
        logic        rst;
    } stim_t;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  cnt;
        logic [3:0]  flg;   // {full, empty, overflow, underflow}
        logic [15:0] nxt;
        logic        chk_nxt;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] obs_nxt;

    // Reference model state
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_stk [4];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        m_known = 1'b0;

    function automatic stim_t st(input logic e, input logic [2:0] o, input logic t,
                                 input logic [15:0] off, input logic [15:0] tgt,
                                 input logic r);
        stim_t s;
        s.en = e; s.op = o; s.tk = t; s.off = off; s.tgt = tgt; s.rst = r;
        return s;
    endfunction

    // Apply one cycle of stimulus, advance the model, queue the expectation.
    task automatic drive(input stim_t s);
        exp_t        e;
        logic [15:0] nxt;
        @(negedge clk);
        en = s.en; op = s.op; taken = s.tk; offset = s.off; PC_In = s.tgt; reset = s.rst;
        case (s.op)
            BR:        nxt = s.tk ? (m_pc + s.off) : (m_pc + 16'd1);
            JMP, LOAD: nxt = s.tgt;
            CALL:      nxt = s.tgt;
            RET:       nxt = (m_cnt > 0) ? m_stk[m_cnt-1] : (m_pc + 16'd1);
            default:   nxt = m_pc + 16'd1;
        endcase
        e.chk_nxt = m_known;
        e.nxt     = nxt;
        if (!s.rst) begin
            m_pc = 16'h0000; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_known = 1'b1;
        end else if (s.en) begin
            if (s.op == CALL) begin
                if (m_cnt < 4) begin
                    m_stk[m_cnt] = m_pc + 16'd1;
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (s.op == RET) begin
                if (m_cnt > 0) m_cnt--;
                else m_unf = 1'b1;
            end
            m_pc = nxt;
        end
        e.pc  = m_pc;
        e.cnt = 3'(m_cnt);
        e.flg = {m_cnt == 4, m_cnt == 0, m_ovf, m_unf};
        sb.push_back(e);
        #1 obs_nxt = pc_next;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1'b1, INC, 1'b0, 16'h0000, 16'h0000, 1'b0));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0abc, 1'b0));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg ||
                (e.chk_nxt && obs_nxt !== e.nxt)) begin
                errors++;
                $display("FAIL reset[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
        end
        checks++;
        if (PC_output !== 16'h0000 || stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_const: pc=%h empty=%b, expected pc=0000 empty=1", PC_output, stack_empty);
        end
    endtask

    task automatic test_inc_wrap();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1'b1, INC,  1'b0, 16'h0000, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, 3'd6, 1'b0, 16'h0000, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, 3'd7, 1'b0, 16'h0000, 16'h0000, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL inc[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
        end
        checks++;
        if (PC_output !== 16'h0003) begin
            errors++;
            $display("FAIL inc_const: pc=%h, expected 0003", PC_output);
        end
        tbl.delete();
        tbl.push_back(st(1'b1, LOAD, 1'b0, 16'h0000, 16'hffff, 1'b1));
        tbl.push_back(st(1'b1, INC,  1'b0, 16'h0000, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, LOAD, 1'b0, 16'h0000, 16'hffff, 1'b1));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0300, 1'b1));
        tbl.push_back(st(1'b1, RET,  1'b0, 16'h0000, 16'h0000, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL wrap[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
            if (i == 1) begin
                checks++;
                if (PC_output !== 16'h0000) begin
                    errors++;
                    $display("FAIL wrap_const: pc=%h, expected 0000", PC_output);
                end
            end
        end
    endtask

    task automatic test_stall();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1'b1, LOAD, 1'b0, 16'h0000, 16'h0010, 1'b1));
        for (int k = 0; k < 3; k++) tbl.push_back(st(1'b0, JMP, 1'b0, 16'h0000, 16'h1234, 1'b1));
        tbl.push_back(st(1'b0, CALL, 1'b0, 16'h0000, 16'h4444, 1'b1));
        tbl.push_back(st(1'b1, JMP, 1'b0, 16'h0000, 16'h1234, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
        end
        checks++;
        if (PC_output !== 16'h1234 || stack_count !== 3'd0) begin
            errors++;
            $display("FAIL stall_const: pc=%h cnt=%0d, expected pc=1234 cnt=0", PC_output, stack_count);
        end
    endtask

    task automatic test_branch();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1'b1, LOAD, 1'b0, 16'h0000, 16'h0100, 1'b1));
        tbl.push_back(st(1'b1, BR,   1'b1, 16'hfff0, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, BR,   1'b0, 16'hfff0, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, BR,   1'b1, 16'h0005, 16'h0000, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL branch[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
        end
        checks++;
        if (PC_output !== 16'h00f6) begin
            errors++;
            $display("FAIL branch_const: pc=%h, expected 00f6", PC_output);
        end
    endtask

    task automatic test_call_return();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1'b1, LOAD, 1'b0, 16'h0000, 16'h0020, 1'b1));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0200, 1'b1));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0300, 1'b1));
        tbl.push_back(st(1'b1, RET,  1'b0, 16'h0000, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, RET,  1'b0, 16'h0000, 16'h0000, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL call_ret[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
        end
        checks++;
        if (PC_output !== 16'h0021 || stack_count !== 3'd0) begin
            errors++;
            $display("FAIL call_ret_const: pc=%h cnt=%0d, expected pc=0021 cnt=0", PC_output, stack_count);
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0400, 1'b1));
        tbl.push_back(st(1'b1, RET,  1'b0, 16'h0000, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0600, 1'b1));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0700, 1'b1));
        tbl.push_back(st(1'b1, RET,  1'b0, 16'h0000, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, RET,  1'b0, 16'h0000, 16'h0000, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL b2b[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
        end
        checks++;
        if (PC_output !== 16'h0023) begin
            errors++;
            $display("FAIL b2b_const: pc=%h, expected 0023", PC_output);
        end
    endtask

    task automatic test_overflow_underflow();
        stim_t tbl[$];
        exp_t  e;
        for (int k = 0; k < 5; k++) tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h1000 + 16'(k), 1'b1));
        for (int k = 0; k < 5; k++) tbl.push_back(st(1'b1, RET, 1'b0, 16'h0000, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, INC,  1'b0, 16'h0000, 16'h0000, 1'b1));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h2000, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL ovf_unf[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
            if (i == 4) begin
                checks++;
                if (PC_output !== 16'h1004 || stack_count !== 3'd4 || overflow !== 1'b1 || stack_full !== 1'b1) begin
                    errors++;
                    $display("FAIL overflow_const: pc=%h cnt=%0d ovf=%b full=%b, expected pc=1004 cnt=4 ovf=1 full=1",
                             PC_output, stack_count, overflow, stack_full);
                end
            end
            if (i == 9) begin
                checks++;
                if (PC_output !== 16'h0025 || underflow !== 1'b1 || stack_count !== 3'd0) begin
                    errors++;
                    $display("FAIL underflow_const: pc=%h unf=%b cnt=%0d, expected pc=0025 unf=1 cnt=0",
                             PC_output, underflow, stack_count);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL sticky_const: ovf=%b unf=%b, expected 1 1", overflow, underflow);
        end
    endtask

    task automatic test_reset_mid();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1'b1, INC,  1'b0, 16'h0000, 16'h0000, 1'b0));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0a00, 1'b1));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0b00, 1'b1));
        tbl.push_back(st(1'b1, CALL, 1'b0, 16'h0000, 16'h0500, 1'b1));
        tbl.push_back(st(1'b1, RET,  1'b0, 16'h0000, 16'h0000, 1'b0));
        tbl.push_back(st(1'b1, RET,  1'b0, 16'h0000, 16'h0000, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL reset_mid[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
            if (i == 4) begin
                checks++;
                if (PC_output !== 16'h0000 || stack_count !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_const: pc=%h cnt=%0d ovf=%b unf=%b, expected 0000 0 0 0",
                             PC_output, stack_count, overflow, underflow);
                end
            end
        end
        checks++;
        if (underflow !== 1'b1 || PC_output !== 16'h0001) begin
            errors++;
            $display("FAIL reset_mid_unf: unf=%b pc=%h, expected unf=1 pc=0001", underflow, PC_output);
        end
    endtask

    task automatic test_random();
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 60; i++) begin
            s = st($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   16'($urandom), 16'($urandom), 1'b1);
            drive(s);
            e = sb.pop_front(); checks++;
            if (PC_output !== e.pc || stack_count !== e.cnt ||
                {stack_full, stack_empty, overflow, underflow} !== e.flg || obs_nxt !== e.nxt) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h cnt=%0d flags=%b next=%h, expected pc=%h cnt=%0d flags=%b next=%h",
                         i, PC_output, stack_count, {stack_full, stack_empty, overflow, underflow}, obs_nxt,
                         e.pc, e.cnt, e.flg, e.nxt);
            end
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; op = 3'd0; taken = 1'b0; offset = 16'h0000; PC_In = 16'h0000;
        test_reset();
        test_inc_wrap();
        test_stall();
        test_branch();
        test_call_return();
        test_back_to_back();
        test_overflow_underflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle CPU, replacing the fixed 16-bit load-only PC register. It holds the PC and computes the next PC internally from a small opcode. Supported next-PC modes are increment, conditional relative branch, absolute jump, direct load, and call/return via an internal return-address stack of configurable depth. Its output drives instruction-memory address and the link path.

## Interface
- `WIDTH`, 16: PC and address width in bits.
- `STEP`, 1: increment added for sequential flow and for the call return address.
- `RESET_VECTOR`, 0: PC value after reset.
- `STACK_DEPTH`, 8: return-stack entries, ≥2. Pointer width is `$clog2(STACK_DEPTH+1)`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `en`  in  1  advance enable; 0 = stall, all state held.
- `op`  in  3  next-PC select: 000 INC, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101 LOAD; 110/111 behave as INC.
- `taken`  in  1  branch condition; used by BRANCH only.
- `offset`  in  WIDTH  two's-complement branch displacement.
- `PC_In`  in  WIDTH  absolute target for JUMP, CALL and LOAD.
- `PC_output`  out  WIDTH  registered current PC.
- `pc_next`  out  WIDTH  combinational value `PC_output` takes at the next enabled edge.
- `stack_count`  out  ptr width  number of valid return entries.
- `stack_full` / `stack_empty`  out  1 each  `stack_count == STACK_DEPTH` / `== 0`.
- `overflow` / `underflow`  out  1 each  sticky error flags.

## Operation
- Reset (`reset`==0 at an edge):
  - `PC_output` = `RESET_VECTOR`; `stack_count` = 0; `overflow` = `underflow` = 0.
  - Stack RAM contents are not cleared; they are don't-care.
  - Reset has priority over `en` and `op`.
- `en`==0: PC, stack, count and flags all hold. `pc_next` still reflects `op`.
- INC: PC ← PC + STEP.
- BRANCH: PC ← PC + offset if `taken`, else PC + STEP. The offset is sign-extended and added to the current PC, not PC+STEP.
- JUMP and LOAD: PC ← `PC_In`. LOAD is kept as a distinct encoding for legacy datapath control; it behaves identically to JUMP.
- CALL:
  - Not full: push PC + STEP, count +1, PC ← `PC_In`.
  - Full: PC ← `PC_In`, push discarded, count unchanged, `overflow` ← 1.
- RET:
  - Not empty: PC ← top entry, count −1.
  - Empty: PC ← PC + STEP, `underflow` ← 1.
- Arithmetic is modulo 2^WIDTH. Wrap-around is silent: 16'hFFFF + 1 = 16'h0000. Pushed return addresses wrap the same way.
- `overflow` and `underflow` clear only on reset.
- Stack is LIFO. Top entry = slot `stack_count-1`.

## Timing
- `PC_output` is registered, with one-edge latency from the `op` presented while `en`==1.
- `pc_next` is combinational from `op`, `taken`, `offset`, `PC_In`, stack top and `PC_output`. It has no dependency on `en`.
- Flags and `stack_count` update on the same edge as the PC.
- Back-to-back CALL/RET on consecutive cycles is fully supported. A RET directly after a CALL returns the address pushed on the previous edge.
- Reset deasserted at edge N: the first enabled update happens at edge N+1. The first fetch address is `RESET_VECTOR`.

## Test plan
- Reset and increment: hold `reset`=0 for 2 edges → `PC_output`=0, `stack_empty`=1, flags 0. Release, INC ×3 → PC 1, 2, 3. Wrap check: LOAD 16'hFFFF, then INC → 16'h0000.
- Stall: at PC 16'h0010 with `en`=0 and op=JUMP, `PC_In`=16'h1234, for 3 edges → PC stays 16'h0010. Set `en`=1 → PC 16'h1234 on the next edge.
- Branch: at PC 16'h0100, BRANCH `offset`=16'hFFF0 `taken`=1 → 16'h00F0. Then BRANCH `taken`=0 → 16'h00F1. Also `offset`=16'h0005 from 16'h00F1 → 16'h00F6.
- Call/return nesting, with `STACK_DEPTH`=4:
  - From PC 16'h0020, CALL 16'h0200 → PC 16'h0200, count 1.
  - CALL 16'h0300 → PC 16'h0300, count 2.
  - RET → 16'h0201; RET → 16'h0021; count 0.
- Overflow/underflow:
  - 5 CALLs at depth 4 → `overflow`=1 after the 5th, count 4, PC = 5th target.
  - 4 RETs drain the stack; a 5th RET → `underflow`=1 and PC += 1.
  - Both flags stay set through later ops and clear only on reset.
- Reset mid-operation: with count 3 and PC 16'h0500, assert `reset`=0 together with op=RET → PC = `RESET_VECTOR`, count 0, flags 0. A following RET sets `underflow`.
